// File: rtl/ycbcr_conv_pipe.sv
// Streaming RGB->YCbCr (JFIF full range), LANES pixels/beat, 3-cycle pipeline with a single global stall.
// Optional YCBCR_RAW_OUT_EN exposes the unrounded S2 sums registered alongside S3.
module ycbcr_conv_pipe #(
  parameter int INPUT_WIDTH        = 8,
  parameter int OUTPUT_WIDTH       = 8,
  parameter int SCALE              = 16,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int LANES              = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES*3*INPUT_WIDTH-1:0]       in_rgb,
  input  logic                                 in_last,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES*OUTPUT_WIDTH-1:0]        out_y,
  output logic [LANES*OUTPUT_WIDTH-1:0]        out_cb,
  output logic [LANES*OUTPUT_WIDTH-1:0]        out_cr,
`ifdef YCBCR_RAW_OUT_EN
  output logic [LANES*FIXED_POINT_LENGTH-1:0]  out_y_raw,
  output logic [LANES*FIXED_POINT_LENGTH-1:0]  out_cb_raw,
  output logic [LANES*FIXED_POINT_LENGTH-1:0]  out_cr_raw,
`endif
  output logic                                 out_last
);

  localparam int IW  = INPUT_WIDTH;
  localparam int OW  = OUTPUT_WIDTH;
  localparam int FPL = FIXED_POINT_LENGTH;

  // Coefficients in units of 1e-4, rounded to SCALE bits; the last term of
  // each row is derived so rows sum to exactly 2^SCALE (Y) or 0 (Cb, Cr).
  localparam longint ONE   = longint'(1) << SCALE;
  localparam longint C_YR  = (2990 * ONE + 5000) / 10000;
  localparam longint C_YG  = (5870 * ONE + 5000) / 10000;
  localparam longint C_YB  = ONE - C_YR - C_YG;
  localparam longint C_CBR = -((1687 * ONE + 5000) / 10000);
  localparam longint C_CBB = ONE / 2;
  localparam longint C_CBG = -(C_CBB + C_CBR);
  localparam longint C_CRR = ONE / 2;
  localparam longint C_CRG = -((4187 * ONE + 5000) / 10000);
  localparam longint C_CRB = -(C_CRR + C_CRG);

  localparam logic signed [FPL-1:0] K [9] = '{
    FPL'(C_YR),  FPL'(C_YG),  FPL'(C_YB),
    FPL'(C_CBR), FPL'(C_CBG), FPL'(C_CBB),
    FPL'(C_CRR), FPL'(C_CRG), FPL'(C_CRB)
  };
  localparam logic signed [FPL-1:0] OFFS = FPL'(longint'(128) << SCALE);
  localparam logic signed [FPL-1:0] RND  = FPL'(longint'(1) << (SCALE - 1));
  localparam logic signed [FPL-1:0] MAXV = FPL'((longint'(1) << OW) - 1);

  function automatic logic [OW-1:0] round_sat(input logic signed [FPL-1:0] s);
    logic signed [FPL-1:0] t;
    t = (s + RND) >>> SCALE;
    if (t[FPL-1])      round_sat = '0;
    else if (t > MAXV) round_sat = '1;
    else               round_sat = t[OW-1:0];
  endfunction

  logic en;
  logic v1_q, v2_q, v3_q, l1_q, l2_q, l3_q;
  logic v1_d, v2_d, v3_d, l1_d, l2_d, l3_d;

  // The whole pipe freezes together, so bubbles keep their slots.
  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_last  = l3_q;

  always_comb begin
    v1_d = v1_q;
    v2_d = v2_q;
    v3_d = v3_q;
    l1_d = l1_q;
    l2_d = l2_q;
    l3_d = l3_q;
    if (en) begin
      v1_d = in_valid;
      l1_d = in_valid && in_last;
      v2_d = v1_q;
      l2_d = l1_q;
      v3_d = v2_q;
      l3_d = l2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
      l3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [FPL-1:0] x   [3];
    logic signed [FPL-1:0] p_d [9];
    logic signed [FPL-1:0] p_q [9];
    logic signed [FPL-1:0] s_d [3];
    logic signed [FPL-1:0] s_q [3];
    logic [OW-1:0]         o_d [3];
    logic [OW-1:0]         o_q [3];

    // Components are unsigned; x[0..2] = R, G, B with R in the lane MSBs.
    always_comb begin
      for (int c = 0; c < 3; c++) begin
        x[c] = $signed(FPL'(in_rgb[k*3*IW + (2-c)*IW +: IW]));
      end
      for (int i = 0; i < 9; i++) begin
        p_d[i] = x[i % 3] * K[i];
      end
      s_d[0] = p_q[0] + p_q[1] + p_q[2];
      s_d[1] = p_q[3] + p_q[4] + p_q[5] + OFFS;
      s_d[2] = p_q[6] + p_q[7] + p_q[8] + OFFS;
      for (int c = 0; c < 3; c++) begin
        o_d[c] = round_sat(s_q[c]);
      end
    end

    always_ff @(posedge clk) begin
      if (en) begin
        p_q <= p_d;
        s_q <= s_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  o_q <= '{default: '0};
      else if (en) o_q <= o_d;
    end

    assign out_y [k*OW +: OW] = o_q[0];
    assign out_cb[k*OW +: OW] = o_q[1];
    assign out_cr[k*OW +: OW] = o_q[2];

`ifdef YCBCR_RAW_OUT_EN
    logic signed [FPL-1:0] r_q [3];

    always_ff @(posedge clk) begin
      if (en) r_q <= s_q;
    end

    assign out_y_raw [k*FPL +: FPL] = r_q[0];
    assign out_cb_raw[k*FPL +: FPL] = r_q[1];
    assign out_cr_raw[k*FPL +: FPL] = r_q[2];
`endif
  end

endmodule
